// File: rtl/enc_snapshot.sv
// enc_snapshot: steps the encoder read-channel select, captures each channel into a
// back bank, then swaps it to the front so readers always see one coherent snapshot.
module enc_snapshot #(
    parameter int NUM_ENC = 4,
    parameter int SETTLE  = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        sample_start,
    output logic [3:0]  enc_raddr_chan,
    input  logic [31:0] enc_quad_data,
    input  logic [31:0] enc_perd_data,
    input  logic [31:0] enc_run_data,
    input  logic [3:0]  rd_chan,
    input  logic [1:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  snap_seq,
    output logic        overrun,
    input  logic        overrun_clr
);
    localparam logic [3:0] LAST_CHAN = 4'(NUM_ENC);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_SWAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  chan_q, chan_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        front_q, front_d;
    logic [7:0]  seq_q, seq_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [31:0] rd_data_q, rd_data_d;
    // [bank][channel][word]; channel indexed directly by the 1-based select
    logic [31:0] mem_q [0:1][0:15][0:3];
    logic [31:0] mem_d [0:1][0:15][0:3];

    assign busy           = state_q != ST_IDLE;
    assign enc_raddr_chan = chan_q;
    assign rd_data        = rd_data_q;
    assign done           = done_q;
    assign snap_seq       = seq_q;
    assign overrun        = ovr_q;

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        front_d = front_q;
        seq_d   = seq_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        // a new overrun beats a simultaneous clear
        ovr_d   = (sample_start && busy) ? 1'b1 : overrun_clr ? 1'b0 : ovr_q;
        case (state_q)
            ST_IDLE: if (sample_start) begin
                chan_d  = 4'd1;
                cnt_d   = SETTLE_M1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = (cnt_q == 4'd0) ? ST_CAPTURE : ST_SETTLE;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            ST_CAPTURE: begin
                mem_d[!front_q][chan_q][0] = enc_quad_data;
                mem_d[!front_q][chan_q][1] = enc_perd_data;
                mem_d[!front_q][chan_q][2] = enc_run_data;
                if (chan_q == LAST_CHAN) begin
                    state_d = ST_SWAP;
                end else begin
                    chan_d  = chan_q + 4'd1;
                    cnt_d   = SETTLE_M1;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                front_d = !front_q;
                seq_d   = seq_q + 8'd1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        rd_data_d = (rd_chan == 4'd0 || rd_chan > LAST_CHAN) ? 32'd0 :
                    (rd_sel == 2'd3) ? {16'd0, ovr_q, busy, 6'd0, seq_q} :
                    mem_q[front_q][rd_chan][rd_sel];
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            chan_q    <= 4'd1;
            cnt_q     <= 4'd0;
            front_q   <= 1'b0;
            seq_q     <= 8'd0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rd_data_q <= 32'd0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            front_q   <= front_d;
            seq_q     <= seq_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_enc_snapshot.sv
// tb_enc_snapshot: randomized snapshot/readback bench against a bank-level reference
// model of the snapshot engine (NUM_ENC=4, SETTLE=1).
module tb_enc_snapshot;
    localparam int NUM  = 4;
    localparam int SET  = 1;
    localparam int LAST = NUM * (SET + 1) + 2;

    logic        sysclk, reset, sample_start, overrun_clr;
    logic [3:0]  enc_raddr_chan, rd_chan;
    logic [1:0]  rd_sel;
    logic [31:0] enc_quad_data, enc_perd_data, enc_run_data, rd_data;
    logic        busy, done, overrun;
    logic [7:0]  snap_seq;

    enc_snapshot #(.NUM_ENC(NUM), .SETTLE(SET)) dut (
        .sysclk(sysclk), .reset(reset), .sample_start(sample_start),
        .enc_raddr_chan(enc_raddr_chan), .enc_quad_data(enc_quad_data),
        .enc_perd_data(enc_perd_data), .enc_run_data(enc_run_data),
        .rd_chan(rd_chan), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
        .done(done), .snap_seq(snap_seq), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // encoder block stand-in: per-channel words selected combinationally
    logic [31:0] tab [0:15][0:2];
    assign enc_quad_data = tab[enc_raddr_chan][0];
    assign enc_perd_data = tab[enc_raddr_chan][1];
    assign enc_run_data  = tab[enc_raddr_chan][2];

    logic [31:0] m_front [0:15][0:2];
    logic [7:0]  m_seq;
    logic        m_ovr, m_busy;
    logic [31:0] rd_exp;
    int vectors, errors;

    function automatic logic [31:0] exp_rd(input logic [3:0] ch, input logic [1:0] s);
        if (ch == 4'd0 || ch > 4'(NUM)) return 32'd0;
        if (s == 2'd3) return {16'd0, m_ovr, m_busy, 6'd0, m_seq};
        return m_front[ch][s];
    endfunction

    task automatic tick();
        rd_exp = exp_rd(rd_chan, rd_sel);
        @(posedge sysclk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 16; c++)
            for (int w = 0; w < 3; w++) m_front[c][w] = 32'd0;
        m_seq = 8'd0; m_ovr = 1'b0; m_busy = 1'b0; rd_exp = 32'd0;
    endtask

    task automatic fill_rand();
        for (int c = 0; c < 16; c++)
            for (int w = 0; w < 3; w++) tab[c][w] = $urandom;
    endtask

    task automatic fill_pattern(input logic [31:0] qbase);
        for (int c = 0; c < 16; c++) begin
            tab[c][0] = qbase + 32'(c);
            tab[c][1] = 32'h200 + 32'(c);
            tab[c][2] = 32'h300 + 32'(c);
        end
    endtask

    // one snapshot from start pulse to the done cycle; ends inside the done cycle
    task automatic run_snap(input int extra_at, input int clr_at, input bit rand_rd);
        int e;
        sample_start = 1'b1;
        tick();
        sample_start = 1'b0;
        m_busy = 1'b1;
        for (int c = 1; c <= LAST; c++) begin
            if (c == LAST) begin
                m_busy = 1'b0;
                m_seq++;
                for (int ch = 1; ch <= NUM; ch++)
                    for (int w = 0; w < 3; w++) m_front[ch][w] = tab[ch][w];
            end
            e = (c - 1) / (SET + 1) + 1;
            if (e > NUM) e = NUM;
            vectors += 6;
            if (busy !== m_busy) begin errors++; $display("FAIL busy c=%0d got %b want %b", c, busy, m_busy); end
            if (done !== (c == LAST)) begin errors++; $display("FAIL done c=%0d got %b want %b", c, done, c == LAST); end
            if (snap_seq !== m_seq) begin errors++; $display("FAIL snap_seq c=%0d got %0d want %0d", c, snap_seq, m_seq); end
            if (overrun !== m_ovr) begin errors++; $display("FAIL overrun c=%0d got %b want %b", c, overrun, m_ovr); end
            if (enc_raddr_chan !== 4'(e)) begin errors++; $display("FAIL chan_sel c=%0d got %0d want %0d", c, enc_raddr_chan, e); end
            if (rd_data !== rd_exp) begin errors++; $display("FAIL rd_data c=%0d got %h want %h", c, rd_data, rd_exp); end
            if (c < LAST) begin
                if (rand_rd) begin
                    rd_chan = 4'($urandom_range(0, 6));
                    rd_sel  = 2'($urandom_range(0, 3));
                end
                sample_start = (c == extra_at);
                overrun_clr  = (c == clr_at);
                tick();
                if (c == extra_at) m_ovr = 1'b1;
                else if (c == clr_at) m_ovr = 1'b0;
                sample_start = 1'b0;
                overrun_clr  = 1'b0;
            end
        end
    endtask

    task automatic read_sweep(input int n_rand);
        for (int i = 0; i < 28 + n_rand; i++) begin
            rd_chan = (i < 28) ? 4'(i / 4) : 4'($urandom_range(0, 6));
            rd_sel  = (i < 28) ? 2'(i % 4) : 2'($urandom_range(0, 3));
            tick();
            vectors++;
            if (rd_data !== rd_exp) begin
                errors++;
                $display("FAIL read ch=%0d sel=%0d got %h want %h", rd_chan, rd_sel, rd_data, rd_exp);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge sysclk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        if (snap_seq !== 8'd0) begin errors++; $display("FAIL rst_seq got %0d want 0", snap_seq); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", overrun); end
        if (enc_raddr_chan !== 4'd1) begin errors++; $display("FAIL rst_chan got %0d want 1", enc_raddr_chan); end
        if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd got %h want 0", rd_data); end
        read_sweep(8);
    endtask

    task automatic test_single();
        fill_pattern(32'h100);
        run_snap(0, 0, 1'b0);
        rd_chan = 4'd3; rd_sel = 2'd1;
        tick();
        vectors += 2;
        if (rd_data !== 32'h203) begin errors++; $display("FAIL t1_read got %h want 00000203", rd_data); end
        if (enc_raddr_chan !== 4'(NUM)) begin errors++; $display("FAIL t1_hold_chan got %0d want %0d", enc_raddr_chan, NUM); end
        read_sweep(8);
    endtask

    task automatic test_overrun();
        fill_rand();
        run_snap(4, 0, 1'b0);
        rd_chan = 4'd1; rd_sel = 2'd3;
        tick();
        vectors++;
        if (rd_data[15] !== 1'b1) begin errors++; $display("FAIL t2_status_bit15 got %b want 1", rd_data[15]); end
        fill_rand();
        run_snap(0, 6, 1'b1);
        fill_rand();
        run_snap(3, 3, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        m_ovr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL t2_clear got %b want 0", overrun); end
        read_sweep(4);
    endtask

    task automatic test_no_glitch();
        rd_chan = 4'd2; rd_sel = 2'd0;
        fill_pattern(32'h100);
        run_snap(0, 0, 1'b0);
        tick();
        vectors++;
        if (rd_data !== 32'h102) begin errors++; $display("FAIL t3_first got %h want 00000102", rd_data); end
        fill_pattern(32'h500);
        run_snap(0, 0, 1'b0);
        tick();
        vectors++;
        if (rd_data !== 32'h502) begin errors++; $display("FAIL t3_second got %h want 00000502", rd_data); end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        sample_start = 1'b1;
        tick();
        sample_start = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        model_clear();
        vectors += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b want 0", busy); end
        if (snap_seq !== 8'd0) begin errors++; $display("FAIL t5_seq got %0d want 0", snap_seq); end
        if (enc_raddr_chan !== 4'd1) begin errors++; $display("FAIL t5_chan got %0d want 1", enc_raddr_chan); end
        if (rd_data !== 32'd0) begin errors++; $display("FAIL t5_rd got %h want 0", rd_data); end
        if (done !== 1'b0) begin errors++; $display("FAIL t5_done got %b want 0", done); end
        reset = 1'b1;
        read_sweep(4);
        fill_rand();
        run_snap(0, 0, 1'b1);
        read_sweep(8);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 256; n++) begin
            fill_rand();
            run_snap(0, 0, 1'b1);
        end
        vectors += 2;
        if (snap_seq !== 8'd0) begin errors++; $display("FAIL t6_wrap got %0d want 0", snap_seq); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL t6_overrun got %b want 0", overrun); end
        read_sweep(8);
    endtask

    initial begin
        vectors = 0; errors = 0;
        sample_start = 1'b0; overrun_clr = 1'b0;
        rd_chan = 4'd0; rd_sel = 2'd0;
        fill_pattern(32'h100);
        test_reset();
        test_single();
        test_overrun();
        test_no_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
